// File: rtl/conv3x3_win_mac.sv
// 3x3 window MAC stage: tracks stream position behind the line buffer, qualifies
// windows and produces one saturated 8-bit feature-map pixel per valid window.
//
// state    | meaning
// ST_IDLE  | waiting for start; sel latched into the frame size on start
// ST_RUN   | one pixel enters per cycle; row/col follow the pixel entered last cycle
// ST_DRAIN | last window issued; flushing the MAC pipeline before returning to idle
module conv3x3_win_mac #(
    parameter int COL1  = 8,
    parameter int COL2  = 14,
    parameter int COL3  = 28,
    parameter int COL4  = 56,
    parameter int COL5  = 112,
    parameter int COL6  = 224,
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2:0]              sel,
    input  logic [71:0]             ifm_win3x3_batch,
    input  logic [71:0]             weights,
    input  logic signed [ACC_W-1:0] bias,
    input  logic [4:0]              shift,
    input  logic                    relu_en,
    output logic [7:0]              ofm_out,
    output logic                    ofm_valid,
    output logic                    busy,
    output logic                    frame_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    localparam logic signed [ACC_W-1:0] C_U8_MAX = ACC_W'(255);
    localparam logic signed [ACC_W-1:0] C_S8_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] C_S8_MIN = ACC_W'(-128);
    localparam logic signed [ACC_W-1:0] C_ZERO   = '0;

    state_t r_state, w_state_nxt;

    logic [7:0] r_row, r_col, r_w_m1, w_sel_m1;
    logic [1:0] r_drain;
    logic       w_last_pix, w_win_valid, w_win_last;

    logic signed [16:0]      w_prod [9];
    logic signed [16:0]      r_prod [9];
    logic signed [ACC_W-1:0] w_sum, r_acc, w_shr;
    logic [7:0]              w_sat;
    logic                    r_v1, r_v2, r_l1, r_l2;

    always_comb begin
        case (sel)
            3'd0:    w_sel_m1 = 8'(COL1 - 1);
            3'd1:    w_sel_m1 = 8'(COL2 - 1);
            3'd2:    w_sel_m1 = 8'(COL3 - 1);
            3'd3:    w_sel_m1 = 8'(COL4 - 1);
            3'd4:    w_sel_m1 = 8'(COL5 - 1);
            default: w_sel_m1 = 8'(COL6 - 1);
        endcase
    end

    assign w_last_pix  = (r_row == r_w_m1) && (r_col == r_w_m1);
    assign w_win_valid = (r_state == ST_RUN) && (r_row >= 8'd2) && (r_col >= 8'd2);
    assign w_win_last  = (r_state == ST_RUN) && w_last_pix;
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)         w_state_nxt = ST_RUN;
            ST_RUN:   if (w_last_pix)    w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_drain == '0) w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    // row/col lag the stream by one cycle: they name the pixel whose window is on the input now
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row   <= '0;
            r_col   <= '0;
            r_w_m1  <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_w_m1 <= w_sel_m1;
                        r_row  <= '0;
                        r_col  <= '0;
                    end
                end
                ST_RUN: begin
                    if (r_col == r_w_m1) begin
                        r_col <= '0;
                        r_row <= r_row + 8'd1;
                    end else begin
                        r_col <= r_col + 8'd1;
                    end
                    if (w_last_pix) r_drain <= 2'd3;
                end
                ST_DRAIN: if (r_drain != '0) r_drain <= r_drain - 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_prod[k] = $signed({9'b0, ifm_win3x3_batch[8*k +: 8]}) *
                        $signed({{9{weights[8*k+7]}}, weights[8*k +: 8]});
        end
    end

    always_comb begin
        w_sum = bias;
        for (int k = 0; k < 9; k++) begin
            w_sum = w_sum + {{(ACC_W-17){r_prod[k][16]}}, r_prod[k]};
        end
    end

    assign w_shr = r_acc >>> shift;

    always_comb begin
        w_sat = w_shr[7:0];
        if (relu_en) begin
            if (w_shr < C_ZERO)        w_sat = 8'h00;
            else if (w_shr > C_U8_MAX) w_sat = 8'hFF;
        end else begin
            if (w_shr < C_S8_MIN)      w_sat = 8'h80;
            else if (w_shr > C_S8_MAX) w_sat = 8'h7F;
        end
    end

    always_ff @(posedge clk) begin
        if (w_win_valid) begin
            for (int k = 0; k < 9; k++) r_prod[k] <= w_prod[k];
        end
        if (r_v1) r_acc <= w_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_l1       <= 1'b0;
            r_l2       <= 1'b0;
            ofm_valid  <= 1'b0;
            frame_done <= 1'b0;
            ofm_out    <= '0;
        end else begin
            r_v1       <= w_win_valid;
            r_l1       <= w_win_last;
            r_v2       <= r_v1;
            r_l2       <= r_l1;
            ofm_valid  <= r_v2;
            frame_done <= r_l2;
            if (r_v2) ofm_out <= w_sat;
        end
    end

endmodule
